// File: rtl/router_link_fifo.sv
// router_link_fifo
// ----------------
// Elastic input buffer for one router link channel. Flits enter on the
// upstream req/ack channel, wait in a DEPTH-entry circular store and leave,
// oldest first, on the downstream req/ack channel. Occupancy, an almost-full
// flag and a sticky upstream protocol-error flag are reported.
//
// Handshake (both channels): a flit moves in a cycle where req && ack are
// both high at the rising edge. Once req rises, req and its data stay
// stable until that transfer cycle. The buffer keeps its own out_req and
// out_data stable this way, and flags a violation by upstream on
// overflow_err.
//
// Optional build macro: ROUTER_LINK_FIFO_BYPASS_EN
//   Defined   - when the buffer is empty, an incoming flit is offered
//               downstream in the same cycle (combinational in -> out path).
//   Undefined - out_req/out_data come from registered state only (1-cycle
//               latency).
//
// Parameters:
//   LINK_WIDTH   flit width in bits
//   DEPTH        storage entries (power of two, >= 2)
//   AF_LEVEL     occupancy at or above which almost_full asserts (1..DEPTH)
//
// Ports:
//   clk           router clock, rising-edge
//   rst           asynchronous active-high reset
//   in_req        upstream flit valid
//   in_data       upstream flit
//   in_ack        buffer can accept a flit
//   out_req       head flit available
//   out_data      head flit
//   out_ack       downstream accepts the head flit
//   count         stored flits, 0..DEPTH
//   almost_full   count >= AF_LEVEL
//   overflow_err  sticky upstream stability violation

module router_link_fifo #(
    parameter int LINK_WIDTH = 35,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = DEPTH - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_req,
    input  logic [LINK_WIDTH-1:0]     in_data,
    output logic                      in_ack,
    output logic                      out_req,
    output logic [LINK_WIDTH-1:0]     out_data,
    input  logic                      out_ack,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      almost_full,
    output logic                      overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [LINK_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    // Low while in reset and for the cycle after release, so in_ack only
    // rises on the first clock edge after reset is removed.
    logic                  r_open;
    logic                  r_prev_stall;
    logic [LINK_WIDTH-1:0] r_prev_data;
    logic                  r_ovf;

    logic w_full;
    logic w_empty;
    logic w_in_ack;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_viol;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    // No pass-through when full: a pop in the same cycle does not open in_ack.
    assign w_in_ack = r_open && !w_full;

`ifdef ROUTER_LINK_FIFO_BYPASS_EN
    // Empty buffer with a flit waiting: offer it downstream right away.
    assign w_bypass = w_empty && in_req && r_open;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed flit taken downstream in the same cycle is never stored,
    // and it is not a pop of the store either.
    assign w_push = in_req && w_in_ack && !(w_bypass && out_ack);
    assign w_pop  = !w_empty && out_ack && !w_bypass;

    // Upstream withdrew or altered a flit that was stalled last cycle.
    assign w_viol = r_prev_stall && (!in_req || (in_data != r_prev_data));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_open       <= 1'b0;
            r_prev_stall <= 1'b0;
            r_prev_data  <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_open       <= 1'b1;
            r_prev_stall <= in_req && !w_in_ack;
            r_prev_data  <= in_data;
            r_ovf        <= r_ovf || w_viol;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage is not reset; count and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    assign in_ack       = w_in_ack;
    assign out_req      = !w_empty || w_bypass;
    assign out_data     = w_bypass ? in_data : r_mem[r_rd_ptr];
    assign count        = r_count;
    assign almost_full  = (r_count >= CW'(AF_LEVEL));
    assign overflow_err = r_ovf;

endmodule

// File: tb/tb_router_link_fifo.sv
// Bench for router_link_fifo: randomized and directed flits, a queue-based
// reference of the buffer contents, and a negedge monitor that checks every
// status output and every delivered flit against that reference.

module tb_router_link_fifo;

    localparam int W     = 35;
    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 1;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef ROUTER_LINK_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          in_req;
    logic [W-1:0]  in_data;
    logic          in_ack;
    logic          out_req;
    logic [W-1:0]  out_data;
    logic          out_ack;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          overflow_err;

    always #5 clk = ~clk;

    router_link_fifo #(.LINK_WIDTH(W), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_req       (in_req),
        .in_data      (in_data),
        .in_ack       (in_ack),
        .out_req      (out_req),
        .out_data     (out_data),
        .out_ack      (out_ack),
        .count        (count),
        .almost_full  (almost_full),
        .overflow_err (overflow_err)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic         m_open = 1'b0;
    logic         m_prev_stall = 1'b0;
    logic [W-1:0] m_prev_data = '0;
    logic         m_ovf = 1'b0;
    logic         wrap_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, want, $time);
        end
    endtask

    // ---------------- monitor ----------------
    // Expected state comes from the queue: occupancy is its size, in_ack
    // follows "not full and out of reset", transfers are decided from the
    // expected handshake values.
    always @(negedge clk) begin
        int           sz;
        logic         e_in_ack;
        logic         e_out_req;
        logic         viol;
        logic [W-1:0] want;
        if (rst) begin
            chk("rst_in_ack", 64'(in_ack), 64'(0));
            chk("rst_out_req", 64'(out_req), 64'(0));
            chk("rst_count", 64'(count), 64'(0));
            chk("rst_af", 64'(almost_full), 64'(0));
            chk("rst_ovf", 64'(overflow_err), 64'(0));
            exp_q.delete();
            m_open       = 1'b0;
            m_prev_stall = 1'b0;
            m_ovf        = 1'b0;
        end else begin
            sz        = exp_q.size();
            e_in_ack  = m_open && (sz < DEPTH);
            e_out_req = (sz != 0) || (BYP && m_open && in_req && (sz == 0));
            chk("in_ack", 64'(in_ack), 64'(e_in_ack));
            chk("out_req", 64'(out_req), 64'(e_out_req));
            chk("count", 64'(count), 64'(sz));
            chk("almost_full", 64'(almost_full), 64'(sz >= AF));
            chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
            viol = m_prev_stall && (!in_req || (in_data != m_prev_data));
            if (in_req && e_in_ack) exp_q.push_back(in_data);
            if (e_out_req && out_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_empty actual=%0h required=none t=%0t", out_data, $time);
                end else begin
                    want = exp_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(want));
                end
            end
            m_ovf        = m_ovf || viol;
            m_prev_stall = in_req && !e_in_ack;
            m_prev_data  = in_data;
            m_open       = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the flit stable until it is accepted, then drop in_req.
    task automatic send_flit(input logic [W-1:0] d);
        logic acc;
        int   n;
        in_req  = 1'b1;
        in_data = d;
        acc     = 1'b0;
        n       = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ack;
            tick();
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=%0h required=accepted t=%0t", d, $time);
        end
        in_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n;
        out_ack = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 t=%0t", exp_q.size(), $time);
        end
        out_ack = 1'b0;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b0;
        in_req  = 1'b0;
        in_data = '0;
        out_ack = 1'b0;
        #1 rst  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();

        // Fill to full, then hold a fifth flit that must not be stored.
        for (int i = 1; i <= DEPTH; i++) send_flit(W'(i));
        in_req  = 1'b1;
        in_data = W'(5);
        tick();
        tick();
        tick();
        // Full with a pending request: one pop, no push; push lands next cycle.
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        tick();
        in_req = 1'b0;
        tick();
        drain();

        // Reset with two flits stored.
        send_flit(W'(35'h7_0000_00AA));
        send_flit(W'(35'h1_2345_6789));
        tick();
        do_reset();
        tick();

        // Back-to-back streaming.
        out_ack = 1'b1;
        for (int i = 0; i < 20; i++) send_flit(W'(i));
        tick();
        drain();

        // Wrap: 3*DEPTH random flits with random downstream acceptance.
        wrap_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3 * DEPTH; i++) send_flit({$urandom_range(0, 7), $urandom});
                wrap_done = 1'b1;
            end
            begin
                while (!wrap_done) begin
                    tick();
                    out_ack = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        // Random traffic with idle gaps on both sides.
        wrap_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send_flit({$urandom_range(0, 7), $urandom});
                end
                wrap_done = 1'b1;
            end
            begin
                while (!wrap_done) begin
                    tick();
                    out_ack = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // Protocol error: withdraw a stalled flit; flag sticks until reset.
        for (int i = 0; i < DEPTH; i++) send_flit(W'(32'hA0 + i));
        in_req  = 1'b1;
        in_data = W'(32'hBAD);
        tick();
        tick();
        in_req = 1'b0;
        repeat (4) tick();
        chk("ovf_sticky", 64'(overflow_err), 64'(1));
        do_reset();
        tick();
        chk("ovf_cleared", 64'(overflow_err), 64'(0));

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
